// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce FSM: state encoding and counter sizing.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // A one-cycle debounce still needs a 1-bit counter to hold zero.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/signal_synchronizer.sv
// Multi-flop synchronizer for an asynchronous level; q is the last stage.
module signal_synchronizer #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button level: synchronize, then accept a new level only
// after it has been steady for DEBOUNCE_CYCLES cycles.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter int   SYNC_STAGES     = 2,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_out,
    output logic settling
);

    localparam int              CW          = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_TC      = CW'(DEBOUNCE_CYCLES - 1);
    localparam state_t          RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic          w_s;
    state_t        r_state,   w_state_nxt;
    logic [CW-1:0] r_cnt,     w_cnt_nxt;
    logic          r_btn_out, w_btn_nxt;
    logic          r_settling;

    signal_synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RESET_STATE;
            r_cnt      <= '0;
            r_btn_out  <= RESET_LEVEL;
            r_settling <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_btn_out  <= w_btn_nxt;
            r_settling <= (w_state_nxt == WAIT_HI) || (w_state_nxt == WAIT_LO);
        end
    end

    // A return to the accepted level is checked before terminal count, so it wins the tie.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_btn_nxt   = r_btn_out;
        case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TC) begin
                    w_state_nxt = STABLE_HI;
                    w_btn_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TC) begin
                    w_state_nxt = STABLE_LO;
                    w_btn_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = RESET_STATE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign btn_out  = r_btn_out;
    assign settling = r_settling;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed vector bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_button_debouncer;

    typedef struct {
        logic rst;
        logic btn;
        logic out;
        logic set;
    } vec_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, btn0 = 1'b1;
    logic rst1 = 1'b1, btn1 = 1'b1;
    logic out0, set0, out1, set1;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .RESET_LEVEL     (1'b0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst0),
        .btn_in   (btn0),
        .btn_out  (out0),
        .settling (set0)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .RESET_LEVEL     (1'b1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .btn_in   (btn1),
        .btn_out  (out1),
        .settling (set1)
    );

    task automatic add(input logic r, input logic b, input logic o, input logic s);
        vec_t v;
        v.rst = r; v.btn = b; v.out = o; v.set = s;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    initial begin
        // Reset held 3 cycles with the button already pressed.
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0);
        // Press after release: settling edges 3..6, btn_out rises at edge 7.
        add(0, 1, 0, 0); add(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1);
        add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 1, 1, 0);
        // Release: btn_out falls at edge 7.
        add(0, 0, 1, 0); add(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 1);
        add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);
        // Bounce 1,1,1,0,1,1,0,0 then steady 0.
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 1); add(0, 0, 0, 1);
        add(0, 1, 0, 1); add(0, 1, 0, 0); add(0, 0, 0, 1); add(0, 0, 0, 1);
        add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);
        // Four-cycle pulse: drop coincides with terminal count, drop wins.
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 1); add(0, 1, 0, 1);
        add(0, 0, 0, 1); add(0, 0, 0, 1); add(0, 0, 0, 0); add(0, 0, 0, 0);
        add(0, 0, 0, 0); add(0, 0, 0, 0);
        // Reset at edge 5 of a press, then the press restarts from zero.
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 1); add(0, 1, 0, 1);
        add(1, 1, 0, 0);
        add(0, 1, 0, 0); add(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1);
        add(0, 1, 1, 0); add(0, 1, 1, 0);
        // Reset during WAIT_LO forces btn_out from 1 back to 0.
        add(0, 0, 1, 0); add(0, 0, 1, 0); add(0, 0, 1, 1); add(0, 0, 1, 1);
        add(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0);

        // RESET_LEVEL=1 instance: button high through reset, never glitches low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst1 = 1'b1; btn1 = 1'b1;
            @(posedge clk); #1;
            check("rl1_reset_out", i, out1, 1'b1);
            check("rl1_reset_settling", i, set1, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst1 = 1'b0; btn1 = 1'b1;
            @(posedge clk); #1;
            check("rl1_hold_out", i, out1, 1'b1);
            check("rl1_hold_settling", i, set1, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst0 = vecs[i].rst;
            btn0 = vecs[i].btn;
            @(posedge clk); #1;
            check("btn_out", i, out0, vecs[i].out);
            check("settling", i, set0, vecs[i].set);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw, asynchronous push-button or switch level into a clean, single-transition level for the edge detection stage directly downstream. The block synchronizes the input into the `clk` domain and rejects contact bounce. A new level is accepted only after it has been held steady for a programmable number of cycles. The output `btn_out` feeds the edge detector's `sig_in`, so each physical press produces exactly one edge.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the synchronized level must stay steady before acceptance (10 ms at 100 MHz). Legal range is 1 or more.
- `SYNC_STAGES`, default 2: synchronizer flip-flop depth. Legal range is 2 or more.
- `RESET_LEVEL`, default 1'b0: value loaded into the synchronizer, `btn_out` and FSM on reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `btn_in`  in  1  raw, asynchronous, bouncing input.
- `btn_out`  out  1  debounced level, registered.
- `settling`  out  1  high while a candidate transition is being timed.

## Operation
- The synchronizer is a chain of `SYNC_STAGES` flip-flops. Its last stage is `s`. No other logic reads `btn_in`.
- The FSM has four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- Counter `cnt` has width max(1, $clog2(DEBOUNCE_CYCLES)) and is unsigned. It must never wrap.
- STABLE_LO:
  - If `s`=1, go to WAIT_HI with `cnt`<=0.
  - Otherwise hold.
- WAIT_HI:
  - If `s`=0, return to STABLE_LO with `cnt`<=0. `btn_out` is unchanged; the bounce is rejected.
  - If `s`=1 and `cnt`==DEBOUNCE_CYCLES-1, go to STABLE_HI with `btn_out`<=1 and `cnt`<=0.
  - Otherwise `cnt`<=`cnt`+1.
- STABLE_HI and WAIT_LO mirror the two rules above with the levels inverted.
- `btn_out` changes only on a WAIT to STABLE transition.
- `settling` is high exactly when the state is WAIT_HI or WAIT_LO. It is registered.
- Reset values:
  - Every synchronizer stage = RESET_LEVEL.
  - `btn_out` = RESET_LEVEL.
  - State = STABLE_HI if RESET_LEVEL is 1, otherwise STABLE_LO.
  - `cnt` = 0.
  - `settling` = 0.
- Reset takes priority over every other condition.
- Reset asserted mid-WAIT abandons the candidate. `btn_out` goes to RESET_LEVEL on the next edge, even if it was at the opposite level.
- Input returning to the accepted level on the same edge that `cnt` would reach terminal: the return wins. There is no transition.

## Timing
- Latency from the first edge that samples a new steady `btn_in` level to the `btn_out` change is exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges:
  - `s` updates at edge SYNC_STAGES.
  - The FSM enters WAIT at edge SYNC_STAGES+1.
  - `btn_out` updates at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- `settling` rises on the WAIT-entry edge. It falls on the same edge that `btn_out` changes, or on the edge of a bounce rejection.
- Any pulse on `btn_in` shorter than DEBOUNCE_CYCLES cycles, as seen at `s`, never reaches `btn_out`.
- Minimum spacing between `btn_out` transitions is DEBOUNCE_CYCLES+1 cycles.
- No combinational path from any input to any output.

## Structure
- Shared package `debounce_pkg` holds:
  - The state encoding constants (2 bits: STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3).
  - Helper function `cnt_width(DEBOUNCE_CYCLES)`.
- Sub-module `signal_synchronizer` has parameters STAGES and RESET_LEVEL and ports `clk`, `rst`, `d`, `q`. It is reused by other asynchronous-input blocks.
- The FSM and counter live in `button_debouncer`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2, so latency = 7 edges.
- Reset: hold `rst`=1 for 3 cycles with `btn_in`=1 and RESET_LEVEL=0. Required: `btn_out`=0 and `settling`=0 throughout. After release with `btn_in`=1, `btn_out` rises at edge 7.
- Clean press: with `btn_in` at 0, switch it to 1 and hold. Required: `settling`=1 from edge 3 to edge 7, `btn_out` rises at edge 7, no further change.
- Bounce: drive `btn_in` with pattern 1,1,1,0,1,1,0,0 then steady 0. Required: `btn_out` stays 0 and `settling` ends at 0.
- Release: with `btn_out`=1, switch `btn_in` to 0 and hold. Required: `btn_out` falls at edge 7. The downstream edge detector sees exactly one edge.
- Reset mid-WAIT: assert `rst` at edge 5 of a press. Required: `btn_out`=0 and `settling`=0 on the next edge, and the press is restarted from zero afterwards.
- RESET_LEVEL=1 with `btn_in`=1 held through reset. Required: `btn_out`=1 continuously with no glitch to 0.
